alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Upstream front-end for the multi-cycle ALU top level. Accepts one operation per valid/ready request
//  (op, X, Y) and generates the ALU start pulse and operand-byte sequence on the ALU inbus.
//  Waits for the ALU finish, captures the 1- or 2-byte result and returns it on a valid/ready response channel.
//  One operation in flight; requests are back-pressured while busy.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles in WAIT before abort (used only with ALU_SEQ_TIMEOUT_EN)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous, active-high reset
//  req_valid   in   1  request present
//  req_ready   out  1  sequencer can accept (high only in IDLE)
//  req_op      in   2  00 ADD, 01 SUB, 10 MUL, 11 DIV
//  req_x       in   8  operand X (dividend / multiplicand / minuend)
//  req_y       in   8  operand Y (divisor / multiplier / subtrahend)
//  rsp_valid   out  1  result present, held until rsp_ready
//  rsp_ready   in   1  consumer accepts result
//  rsp_hi      out  8  MUL: product[15:8]; DIV: remainder; ADD/SUB: 0
//  rsp_lo      out  8  MUL: product[7:0]; DIV: quotient; ADD/SUB: result
//  rsp_err     out  1  DIV by zero (or timeout, if enabled); hi/lo = 0
//  alu_op      out  2  to ALU op, held from START to end of capture
//  alu_start   out  1  to ALU start, one-cycle pulse
//  alu_inbus   out  8  to ALU inbus
//  alu_outbus  in   8  from ALU outbus
//  alu_finish  in   1  from ALU finish, high 1 cycle (ADD/SUB) or 2 cycles (MUL/DIV)
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_hi=rsp_lo=0; rsp_err=0; alu_start=0; alu_op=0; alu_inbus=0.
//  Registers are cleared by rst at any point, including mid-operation. Reset is not propagated to the ALU;
//  the ALU shares the same rst.
//  FSM: IDLE -> START -> LOAD_X -> LOAD_Y -> WAIT -> (CAP2) -> RESP -> IDLE.
//  IDLE:   req_ready=1; on req_valid latch op/x/y.
//          - op=DIV and y=0: go to RESP with rsp_err=1. The ALU is not started.
//          - Otherwise: go to START.
//  START:  alu_start=1, alu_op=op, alu_inbus=0 (exactly one cycle).
//  LOAD_X: alu_inbus=X. LOAD_Y: alu_inbus=Y. Each lasts one cycle; alu_inbus returns to 0 afterwards.
//  WAIT:   on alu_finish:
//          - ADD/SUB: capture alu_outbus into rsp_lo, set rsp_hi=0, go to RESP.
//          - MUL/DIV: capture alu_outbus into rsp_hi, go to CAP2.
//  CAP2:   capture alu_outbus into rsp_lo unconditionally (the second finish cycle), go to RESP.
//  RESP:   rsp_valid=1, outputs stable; on rsp_ready go to IDLE.
//          - req_ready stays 0 in the accepting cycle, so there is no same-cycle re-accept.
//  Latency: request accept -> alu_start = 1 cycle. Last finish cycle -> rsp_valid = 1 cycle.
//  Extra alu_finish outside WAIT/CAP2 is ignored. alu_outbus is sampled only in WAIT/CAP2.
//  req_valid while busy: no accept, and req_* are not sampled.
//  All values are 8-bit unsigned/two's complement as the ALU defines them; no width extension here.
// CONFIGURATION
//  ALU_SEQ_TIMEOUT_EN defined:
//    - A counter runs in WAIT/CAP2. Reaching TIMEOUT_CYCLES without finish -> RESP with rsp_err=1, hi=lo=0.
//    - The next op starts normally; the ALU must have returned to idle (caller may pulse rst).
//  Not defined: no counter; WAIT waits indefinitely and rsp_err is raised only for DIV by zero.
// STRUCTURE
//  Shared package alu_pkg:
//    - op encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV;
//    - sequencer state encoding;
//    - helper constant giving result byte count per op.
//  Flat single module. The optional timeout counter is sub-module alu_seq_timer (clear, enable, expired).
// TESTING
//  ADD x=8'h12 y=8'h34 -> start pulse 1 cycle after accept, inbus 00,12,34; rsp_lo=8'h46, rsp_hi=0, err=0.
//  MUL x=8'd13 y=8'd11 -> two finish cycles captured; rsp_hi=8'h00, rsp_lo=8'h8F.
//  DIV x=8'd100 y=8'd7 -> rsp_lo=8'd14, rsp_hi=8'd2. DIV y=0 -> alu_start never asserts, rsp_err=1 next cycle.
//  Back-pressure: rsp_ready=0 for 10 cycles -> rsp_valid/data stable, req_ready=0;
//    a second req_valid is held pending, then accepted in IDLE.
//  rst asserted in WAIT -> next cycle all outputs at reset values; a following SUB 8'h05-8'h07 -> rsp_lo=8'hFE.
//  ALU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, finish withheld -> rsp_err=1 exactly 8 cycles after entering WAIT.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_pkg: op encodings, sequencer states, result byte count helper     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package alu_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t OP_ADD = 2'b00;
  localparam alu_op_t OP_SUB = 2'b01;
  localparam alu_op_t OP_MUL = 2'b10;
  localparam alu_op_t OP_DIV = 2'b11;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_LOAD_X = 3'd2;
  localparam logic [2:0] S_LOAD_Y = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_CAP2   = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  // MUL/DIV return two bytes over two finish cycles (hi first), ADD/SUB one.
  function automatic logic [1:0] result_bytes(input alu_op_t op);
    return ((op == OP_MUL) || (op == OP_DIV)) ? 2'd2 : 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_seq_timer: WAIT-phase watchdog, built only with ALU_SEQ_TIMEOUT_EN |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`ifdef ALU_SEQ_TIMEOUT_EN
module alu_seq_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Count is 0 in the first enabled cycle, so expiry fires in cycle TIMEOUT_CYCLES-1.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule
`endif
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_sequencer: valid/ready front-end driving the multi-cycle ALU bus  |
// | Option macro: ALU_SEQ_TIMEOUT_EN. Revision: 1.0                       |
// +-----------------------------------------------------------------------+
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_x,
  input  logic [7:0] req_y,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_hi,
  output logic [7:0] rsp_lo,
  output logic       rsp_err,
  output logic [1:0] alu_op,
  output logic       alu_start,
  output logic [7:0] alu_inbus,
  input  logic [7:0] alu_outbus,
  input  logic       alu_finish
);

  logic [2:0] state;
  alu_op_t    op_q;
  logic [7:0] x_q;
  logic [7:0] y_q;
  logic       timed_out;
  logic       in_wait;

  assign in_wait = (state == S_WAIT) || (state == S_CAP2);

`ifdef ALU_SEQ_TIMEOUT_EN
  alu_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(timed_out)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timed_out          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      rsp_hi  <= 8'h00;
      rsp_lo  <= 8'h00;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            x_q    <= req_x;
            y_q    <= req_y;
            rsp_hi <= 8'h00;
            rsp_lo <= 8'h00;
            // Divide by zero is answered locally; the ALU never sees it.
            if ((req_op == OP_DIV) && (req_y == 8'h00)) begin
              rsp_err <= 1'b1;
              state   <= S_RESP;
            end else begin
              rsp_err <= 1'b0;
              state   <= S_START;
            end
          end
        end
        S_START:  state <= S_LOAD_X;
        S_LOAD_X: state <= S_LOAD_Y;
        S_LOAD_Y: state <= S_WAIT;
        S_WAIT: begin
          if (alu_finish) begin
            if (result_bytes(op_q) == 2'd2) begin
              rsp_hi <= alu_outbus;
              state  <= S_CAP2;
            end else begin
              rsp_hi <= 8'h00;
              rsp_lo <= alu_outbus;
              state  <= S_RESP;
            end
          end else if (timed_out) begin
            rsp_err <= 1'b1;
            state   <= S_RESP;
          end
        end
        S_CAP2: begin
          rsp_lo <= alu_outbus;
          state  <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign alu_start = (state == S_START);

  always_comb begin
    alu_op = OP_ADD;
    if ((state == S_START) || (state == S_LOAD_X) || (state == S_LOAD_Y) || in_wait) begin
      alu_op = op_q;
    end
  end

  always_comb begin
    alu_inbus = 8'h00;
    case (state)
      S_LOAD_X: alu_inbus = x_q;
      S_LOAD_Y: alu_inbus = y_q;
      default:  alu_inbus = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_sequencer: directed bench; the bench plays the ALU side        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_x = 8'h00;
  logic [7:0] req_y = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_hi;
  logic [7:0] rsp_lo;
  logic       rsp_err;
  logic [1:0] alu_op;
  logic       alu_start;
  logic [7:0] alu_inbus;
  logic [7:0] alu_outbus = 8'hAA;
  logic       alu_finish = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic       o_start0, o_start1, o_rdy0, o_valid_pre, o_valid_a, o_valid_b;
  logic       o_rdy_acc, o_rdy_after, o_valid_after;
  logic [1:0] o_op0, o_op3;
  logic [7:0] o_in0, o_in1, o_in2, o_in3;

  alu_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_start(alu_start), .alu_inbus(alu_inbus),
    .alu_outbus(alu_outbus), .alu_finish(alu_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Called at a negedge with the DUT in IDLE; returns at the first WAIT negedge.
  task automatic drive_req(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
    @(negedge clk);
    req_valid = 1'b0;
    o_start0 = alu_start; o_op0 = alu_op; o_in0 = alu_inbus; o_rdy0 = req_ready;
    @(negedge clk);
    o_start1 = alu_start; o_in1 = alu_inbus;
    @(negedge clk);
    o_in2 = alu_inbus;
    @(negedge clk);
    o_in3 = alu_inbus; o_op3 = alu_op;
  endtask

  task automatic drive_finish(input int nfin, input logic [7:0] b1, input logic [7:0] b2, input int dly);
    repeat (dly) @(negedge clk);
    o_valid_pre = rsp_valid;
    alu_finish = 1'b1; alu_outbus = b1;
    @(negedge clk);
    o_valid_a = rsp_valid;
    if (nfin == 2) begin
      alu_outbus = b2;
      @(negedge clk);
      o_valid_b = rsp_valid;
    end
    alu_finish = 1'b0; alu_outbus = 8'hAA;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    o_rdy_acc = req_ready;
    @(negedge clk);
    rsp_ready = 1'b0;
    o_rdy_after = req_ready;
    o_valid_after = rsp_valid;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err, alu_start, alu_op, alu_inbus} !==
        {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset: rdy=%b vld=%b hi=%h lo=%h err=%b st=%b op=%h in=%h, required 1 0 00 00 0 0 0 00",
               req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err, alu_start, alu_op, alu_inbus);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    drive_req(2'b00, 8'h12, 8'h34);
    vectors++;
    if ({o_start0, o_rdy0, o_op0, o_in0} !== {1'b1, 1'b0, 2'b00, 8'h00}) begin
      miscompares++;
      $display("FAIL add_start: st=%b rdy=%b op=%h in=%h, required 1 0 0 00", o_start0, o_rdy0, o_op0, o_in0);
    end
    vectors++;
    if ({o_start1, o_in1, o_in2, o_in3} !== {1'b0, 8'h12, 8'h34, 8'h00}) begin
      miscompares++;
      $display("FAIL add_inbus: st=%b seq=%h,%h,%h, required 0 12,34,00", o_start1, o_in1, o_in2, o_in3);
    end
    drive_finish(1, 8'h46, 8'h00, 2);
    vectors++;
    if ({o_valid_pre, o_valid_a} !== 2'b01) begin
      miscompares++;
      $display("FAIL add_latency: valid before/after finish=%b%b, required 01", o_valid_pre, o_valid_a);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_hi, rsp_lo, rsp_err} !== {1'b1, 8'h00, 8'h46, 1'b0}) begin
      miscompares++;
      $display("FAIL add_result: vld=%b hi=%h lo=%h err=%b, required 1 00 46 0", rsp_valid, rsp_hi, rsp_lo, rsp_err);
    end
    handshake();
    vectors++;
    if ({o_rdy_acc, o_rdy_after, o_valid_after} !== 3'b010) begin
      miscompares++;
      $display("FAIL add_handshake: rdy_acc=%b rdy_after=%b vld_after=%b, required 0 1 0",
               o_rdy_acc, o_rdy_after, o_valid_after);
    end
  endtask

  task automatic test_mul();
    drive_req(2'b10, 8'd13, 8'd11);
    vectors++;
    if ({o_op0, o_op3, o_in1, o_in2} !== {2'b10, 2'b10, 8'd13, 8'd11}) begin
      miscompares++;
      $display("FAIL mul_load: op=%h/%h in=%h,%h, required 2/2 0d,0b", o_op0, o_op3, o_in1, o_in2);
    end
    drive_finish(2, 8'h00, 8'h8F, 0);
    vectors++;
    if ({o_valid_pre, o_valid_a, o_valid_b} !== 3'b001) begin
      miscompares++;
      $display("FAIL mul_latency: valid=%b%b%b, required 001", o_valid_pre, o_valid_a, o_valid_b);
    end
    vectors++;
    if ({rsp_valid, rsp_hi, rsp_lo, rsp_err} !== {1'b1, 8'h00, 8'h8F, 1'b0}) begin
      miscompares++;
      $display("FAIL mul_result: vld=%b hi=%h lo=%h err=%b, required 1 00 8f 0", rsp_valid, rsp_hi, rsp_lo, rsp_err);
    end
    handshake();
  endtask

  task automatic test_div();
    drive_req(2'b11, 8'd100, 8'd7);
    drive_finish(2, 8'd2, 8'd14, 1);
    vectors++;
    if ({rsp_valid, rsp_hi, rsp_lo, rsp_err, o_op3} !== {1'b1, 8'd2, 8'd14, 1'b0, 2'b11}) begin
      miscompares++;
      $display("FAIL div_result: vld=%b hi=%h lo=%h err=%b op=%h, required 1 02 0e 0 3",
               rsp_valid, rsp_hi, rsp_lo, rsp_err, o_op3);
    end
    handshake();
  endtask

  task automatic test_div_zero();
    req_valid = 1'b1; req_op = 2'b11; req_x = 8'd55; req_y = 8'd0;
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if ({alu_start, rsp_valid, rsp_err, rsp_hi, rsp_lo} !== {1'b0, 1'b1, 1'b1, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL div_zero: st=%b vld=%b err=%b hi=%h lo=%h, required 0 1 1 00 00",
               alu_start, rsp_valid, rsp_err, rsp_hi, rsp_lo);
    end
    @(negedge clk);
    vectors++;
    if ({alu_start, rsp_valid} !== 2'b01) begin
      miscompares++;
      $display("FAIL div_zero_hold: st=%b vld=%b, required 0 1", alu_start, rsp_valid);
    end
    handshake();
  endtask

  task automatic test_stray_finish();
    alu_finish = 1'b1; alu_outbus = 8'h77;
    repeat (2) @(negedge clk);
    alu_finish = 1'b0; alu_outbus = 8'hAA;
    vectors++;
    if ({rsp_valid, req_ready, alu_start} !== 3'b010) begin
      miscompares++;
      $display("FAIL stray_finish: vld=%b rdy=%b st=%b, required 0 1 0", rsp_valid, req_ready, alu_start);
    end
  endtask

  task automatic test_back_to_back();
    drive_req(2'b00, 8'h01, 8'h02);
    drive_finish(1, 8'h03, 8'h00, 0);
    req_valid = 1'b1; req_op = 2'b01; req_x = 8'h09; req_y = 8'h04;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_lo, rsp_hi, req_ready, alu_start} !== {1'b1, 8'h03, 8'h00, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: vld=%b lo=%h hi=%h rdy=%b st=%b, required 1 03 00 0 0",
                 i, rsp_valid, rsp_lo, rsp_hi, req_ready, alu_start);
      end
    end
    handshake();
    vectors++;
    if ({o_rdy_acc, o_rdy_after} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_ready: rdy_acc=%b rdy_idle=%b, required 0 1", o_rdy_acc, o_rdy_after);
    end
    drive_req(2'b01, 8'h09, 8'h04);
    vectors++;
    if ({o_start0, o_op0, o_in1, o_in2} !== {1'b1, 2'b01, 8'h09, 8'h04}) begin
      miscompares++;
      $display("FAIL b2b_second: st=%b op=%h in=%h,%h, required 1 1 09,04", o_start0, o_op0, o_in1, o_in2);
    end
    drive_finish(1, 8'h05, 8'h00, 0);
    vectors++;
    if ({rsp_valid, rsp_lo} !== {1'b1, 8'h05}) begin
      miscompares++;
      $display("FAIL b2b_result: vld=%b lo=%h, required 1 05", rsp_valid, rsp_lo);
    end
    handshake();
  endtask

  task automatic test_reset_midop();
    drive_req(2'b10, 8'h03, 8'h04);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err, alu_start, alu_op, alu_inbus} !==
        {1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_midop: rdy=%b vld=%b hi=%h lo=%h err=%b st=%b op=%h in=%h, required 1 0 00 00 0 0 0 00",
               req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err, alu_start, alu_op, alu_inbus);
    end
    drive_req(2'b01, 8'h05, 8'h07);
    drive_finish(1, 8'hFE, 8'h00, 1);
    vectors++;
    if ({rsp_valid, rsp_hi, rsp_lo, rsp_err} !== {1'b1, 8'h00, 8'hFE, 1'b0}) begin
      miscompares++;
      $display("FAIL sub_after_reset: vld=%b hi=%h lo=%h err=%b, required 1 00 fe 0", rsp_valid, rsp_hi, rsp_lo, rsp_err);
    end
    handshake();
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    drive_req(2'b10, 8'h01, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      vectors++;
      if (i < 8) begin
        if (rsp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL timeout_early[%0d]: vld=%b, required 0", i, rsp_valid);
        end
      end else if ({rsp_valid, rsp_err, rsp_hi, rsp_lo} !== {1'b1, 1'b1, 8'h00, 8'h00}) begin
        miscompares++;
        $display("FAIL timeout: vld=%b err=%b hi=%h lo=%h, required 1 1 00 00", rsp_valid, rsp_err, rsp_hi, rsp_lo);
      end
    end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_div_zero();
    test_stray_finish();
    test_back_to_back();
    test_reset_midop();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
